// File: rtl/h264_pkg.sv
// h264_pkg: shared constants and types for the H.264 byte-stream reader.
package h264_pkg;
   localparam logic [7:0] EPB_BYTE = 8'h03;
   localparam int BITBUF_W = 32;
   localparam int PEEK_W   = 24;
   localparam int MAX_SKIP = 24;
   localparam int CNT_W    = $clog2(BITBUF_W) + 1;
   typedef enum logic [1:0] {ZC_NONE, ZC_ONE, ZC_TWO} zc_t;
endpackage

// File: rtl/h264_byte_fifo.sv
// h264_byte_fifo: byte FIFO with extra-bit pointers; read data is the head entry.
module h264_byte_fifo #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          flush_i,
   input  logic                          wr_en_i,
   input  logic [7:0]                    wr_data_i,
   input  logic                          pop_i,
   output logic [7:0]                    rd_data_o,
   output logic                          empty_o,
   output logic                          full_o,
   output logic [$clog2(FIFO_DEPTH):0]   count_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [7:0] mem_q [FIFO_DEPTH];
   logic [AW:0] wp_q, wp_d, rp_q, rp_d;
   always_comb begin
      wp_d = flush_i ? '0 : wp_q + {{AW{1'b0}}, wr_en_i};
      rp_d = flush_i ? '0 : rp_q + {{AW{1'b0}}, pop_i};
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end
   // When full and popping, the write lands on the slot being read out this cycle.
   always_ff @(posedge clk_i) begin
      if (wr_en_i && !flush_i) mem_q[wp_q[AW-1:0]] <= wr_data_i;
   end
   assign rd_data_o = mem_q[rp_q[AW-1:0]];
   assign count_o   = wp_q - rp_q;
   assign empty_o   = count_o == '0;
   assign full_o    = count_o == (AW+1)'(FIFO_DEPTH);
endmodule

// File: rtl/h264_bytes_to_bits.sv
// h264_bytes_to_bits: removes emulation-prevention bytes, buffers RBSP bytes and
// presents a left-aligned bit window to the syntax parser.
module h264_bytes_to_bits
   import h264_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [7:0]          byte_i,
   input  logic                strobe_i,
   output logic                ready_o,
   input  logic                flush_i,
   input  logic                skip_i,
   input  logic [4:0]          skipn_i,
   input  logic                align_i,
   output logic [PEEK_W-1:0]   peek_o,
   output logic [CNT_W-1:0]    avail_o,
   output logic                error_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [7:0] rd_data;
   logic empty, full;
   logic [AW:0] count;
   zc_t zc_q, zc_d;
   logic epb_q, epb_d, err_q, err_d;
   logic [BITBUF_W-1:0] buf_q, buf_d;
   logic [CNT_W-1:0] bcnt_q, bcnt_d, k, r1, rem, cons;
   logic skip_err, pop, drop, lost, wr_en, bad_byte;
   h264_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .flush_i  (flush_i),
      .wr_en_i  (wr_en),
      .wr_data_i(byte_i),
      .pop_i    (pop),
      .rd_data_o(rd_data),
      .empty_o  (empty),
      .full_o   (full),
      .count_o  (count)
   );
   always_comb begin
      k        = skip_i ? CNT_W'(skipn_i) : '0;
      skip_err = skip_i && (skipn_i == '0 || k > bcnt_q);
      r1       = bcnt_q - k;
      // Bits left after skip, then alignment down to a whole-byte remainder.
      rem      = skip_err ? '0 : align_i ? {r1[CNT_W-1:3], 3'b000} : r1;
      cons     = bcnt_q - rem;
      pop      = !flush_i && !empty && rem <= CNT_W'(PEEK_W);
      drop     = strobe_i && zc_q == ZC_TWO && byte_i == EPB_BYTE;
      lost     = strobe_i && !drop && full && !pop;
      wr_en    = strobe_i && !drop && !lost && !flush_i;
      bad_byte = (epb_q && byte_i > EPB_BYTE) || (zc_q == ZC_TWO && byte_i <= 8'h02);
      buf_d    = flush_i ? '0 : (buf_q << cons) | (pop ? {rd_data, {PEEK_W{1'b0}}} >> rem : '0);
      bcnt_d   = flush_i ? '0 : rem + (pop ? CNT_W'(8) : '0);
      zc_d     = flush_i || drop ? ZC_NONE :
                 !wr_en ? zc_q :
                 byte_i != 8'h00 ? ZC_NONE :
                 zc_q == ZC_TWO ? ZC_TWO : zc_t'(zc_q + 2'd1);
      epb_d    = flush_i ? 1'b0 : drop ? 1'b1 : wr_en ? 1'b0 : epb_q;
      err_d    = flush_i ? 1'b0 : err_q | lost | skip_err | (wr_en && bad_byte);
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         zc_q   <= ZC_NONE;
         epb_q  <= 1'b0;
         err_q  <= 1'b0;
         buf_q  <= '0;
         bcnt_q <= '0;
      end else begin
         zc_q   <= zc_d;
         epb_q  <= epb_d;
         err_q  <= err_d;
         buf_q  <= buf_d;
         bcnt_q <= bcnt_d;
      end
   end
   assign peek_o  = buf_q[BITBUF_W-1 -: PEEK_W];
   assign avail_o = bcnt_q;
   assign error_o = err_q;
   assign ready_o = count <= (AW+1)'(FIFO_DEPTH - 4);
endmodule

// File: tb/tb_h264_bytes_to_bits.sv
// tb_h264_bytes_to_bits: table-driven unstuffing vectors with a byte scoreboard,
// plus hand-written sequences for skip/align, overflow, flush and reset.
module tb_h264_bytes_to_bits;
   logic clk, rst_n, strobe, flush, skip, align;
   logic [7:0] byte_in;
   logic [4:0] skipn;
   logic ready, error;
   logic [23:0] peek;
   logic [5:0] avail;
   int n_chk = 0;
   int n_fail = 0;
   logic [7:0] exp_q [$];

   typedef struct {
      logic [47:0] in_b;
      int          n;
      logic [47:0] out_b;
      int          m;
      logic        err;
   } vec_t;
   vec_t vecs [7];

   h264_bytes_to_bits #(.FIFO_DEPTH(16)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .byte_i  (byte_in),
      .strobe_i(strobe),
      .ready_o (ready),
      .flush_i (flush),
      .skip_i  (skip),
      .skipn_i (skipn),
      .align_i (align),
      .peek_o  (peek),
      .avail_o (avail),
      .error_o (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge clk);
      byte_in = b;
      strobe = 1'b1;
   endtask

   task automatic idle();
      @(negedge clk);
      strobe = 1'b0;
   endtask

   task automatic do_flush();
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic do_cons(input logic s, input logic [4:0] n, input logic a);
      @(negedge clk);
      skip = s;
      skipn = n;
      align = a;
      @(negedge clk);
      skip = 1'b0;
      align = 1'b0;
   endtask

   task automatic drain(input string name);
      int budget;
      budget = 300;
      while (exp_q.size() > 0 && budget > 0) begin
         @(negedge clk);
         skip = 1'b0;
         if (avail >= 6'd8) begin
            chk(name, {24'h0, peek[23:16]}, {24'h0, exp_q.pop_front()});
            skip = 1'b1;
            skipn = 5'd8;
         end
         budget--;
      end
      if (exp_q.size() > 0) begin
         chk({name, "_timeout"}, exp_q.size(), 0);
         exp_q.delete();
      end
      @(negedge clk);
      skip = 1'b0;
   endtask

   initial begin
      vecs[0] = '{48'h250000030180, 6, 48'h250000018000, 5, 1'b0};
      vecs[1] = '{48'h000003030000, 4, 48'h000003000000, 3, 1'b0};
      vecs[2] = '{48'h000001000000, 3, 48'h000001000000, 3, 1'b1};
      vecs[3] = '{48'h000003040000, 4, 48'h000004000000, 3, 1'b1};
      vecs[4] = '{48'h000003000003, 6, 48'h000000000000, 4, 1'b0};
      vecs[5] = '{48'h000300000200, 5, 48'h000300000200, 5, 1'b1};
      vecs[6] = '{48'h123400000000, 5, 48'h123400000000, 5, 1'b1};
      rst_n = 1'b0;
      strobe = 1'b0;
      flush = 1'b0;
      skip = 1'b0;
      align = 1'b0;
      skipn = 5'd0;
      byte_in = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_peek", peek, 0);
      chk("rst_avail", avail, 0);
      chk("rst_error", error, 0);

      for (int v = 0; v < 7; v++) begin
         do_flush();
         for (int i = 0; i < vecs[v].m; i++) exp_q.push_back(vecs[v].out_b[47-8*i -: 8]);
         for (int i = 0; i < vecs[v].n; i++) send(vecs[v].in_b[47-8*i -: 8]);
         idle();
         drain($sformatf("vec%0d_byte", v));
         chk($sformatf("vec%0d_error", v), error, vecs[v].err);
         chk($sformatf("vec%0d_avail", v), avail, 0);
      end

      // Full window, one byte still queued, then a 24-bit skip pulls it in.
      do_flush();
      send(8'h25); send(8'h00); send(8'h00); send(8'h03); send(8'h01); send(8'h80);
      idle();
      repeat (6) @(negedge clk);
      chk("win_avail", avail, 32);
      chk("win_peek", peek, 24'h250000);
      do_cons(1'b1, 5'd24, 1'b0);
      chk("win_skip_avail", avail, 16);
      chk("win_skip_peek", peek[23:8], 16'h0180);
      chk("win_error", error, 0);

      // Partial skip then byte alignment.
      do_flush();
      send(8'hA5); send(8'h5A);
      idle();
      repeat (3) @(negedge clk);
      chk("al_avail0", avail, 16);
      do_cons(1'b1, 5'd3, 1'b0);
      chk("al_skip_avail", avail, 13);
      chk("al_skip_peek", peek[23:16], 8'h2A);
      do_cons(1'b0, 5'd0, 1'b1);
      chk("al_align_avail", avail, 8);
      chk("al_align_peek", peek[23:16], 8'h5A);

      // Over-long skip and zero-length skip are both errors that empty the window.
      do_cons(1'b1, 5'd9, 1'b0);
      chk("overskip_error", error, 1);
      chk("overskip_avail", avail, 0);
      do_flush();
      chk("flush_error", error, 0);
      send(8'h77);
      idle();
      repeat (3) @(negedge clk);
      chk("zskip_avail0", avail, 8);
      do_cons(1'b1, 5'd0, 1'b0);
      chk("zskip_error", error, 1);
      chk("zskip_avail", avail, 0);

      // Overflow: 4 bytes in the window, 16 in the FIFO, the 21st lost.
      do_flush();
      for (int i = 0; i < 20; i++) send(8'hFF);
      chk("ovf_no_early_error", error, 0);
      send(8'hFF);
      idle();
      repeat (2) @(negedge clk);
      chk("ovf_ready", ready, 0);
      chk("ovf_error", error, 1);
      chk("ovf_avail", avail, 32);
      for (int i = 0; i < 20; i++) exp_q.push_back(8'hFF);
      drain("ovf_byte");
      chk("ovf_ready_after", ready, 1);
      chk("ovf_avail_after", avail, 0);
      do_flush();
      chk("ovf_flush_error", error, 0);

      // Reset mid-stream restarts the zero counter.
      send(8'h11); send(8'h22); send(8'h33);
      idle();
      repeat (4) @(negedge clk);
      do_cons(1'b1, 5'd4, 1'b0);
      chk("rs_avail20", avail, 20);
      send(8'h00);
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("rs_avail", avail, 0);
      chk("rs_peek", peek, 0);
      chk("rs_ready", ready, 1);
      chk("rs_error", error, 0);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'h03);
      send(8'h00); send(8'h03);
      idle();
      drain("rs_byte");
      chk("rs_error_after", error, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/h264_bytes_to_bits.md
# h264_bytes_to_bits

Byte-stream reader for the H.264 path, the receive-side counterpart of the bit-packing/byte-stuffing encoder output. It accepts NAL payload bytes on a BYTE/STROBE interface and removes emulation-prevention bytes (the 03 in 00 00 03). It buffers the resulting RBSP bytes in a small FIFO and presents them to a downstream syntax parser as a left-aligned bit window. The parser consumes 1–24 bits per cycle and can realign to a byte boundary.

## Interface
- FIFO_DEPTH, 16, byte FIFO entries; power of two, ≥8
- CLK  in  1  clock, all state on rising edge
- RSTN  in  1  reset, asynchronous, active-low
- BYTE  in  8  stuffed input byte
- STROBE  in  1  BYTE valid this cycle
- READY  out  1  advisory: FIFO occupancy ≤ FIFO_DEPTH-4; source stops within 3 strobes of deassertion
- FLUSH  in  1  synchronous clear of FIFO, bit buffer, zero counter, ERROR
- SKIP  in  1  consume SKIPN bits this cycle
- SKIPN  in  5  bits to consume, 1..24
- ALIGN  in  1  discard bits up to next byte boundary
- PEEK  out  24  next 24 bits, MSB = oldest bit; bits beyond AVAIL are 0
- AVAIL  out  6  valid bits in buffer, 0..32
- ERROR  out  1  sticky error flag

## Operation
- Unstuff stage, zero counter zc (0..2, saturating), acts on STROBE:
  - zc==2 and BYTE==03: byte dropped; zc←0; arm flag epb←1.
  - Otherwise: byte written to FIFO; zc←(BYTE==00) ? min(zc+1,2) : 0.
  - epb clears on the next strobed byte. If that byte is >03, ERROR←1; the byte is still written.
  - zc==2 and BYTE∈{00,01,02} (unstuffed start-code pattern): ERROR←1; byte still written.
  - STROBE while FIFO full: byte lost, ERROR←1; zc and epb do not advance.
- Bit buffer: 32-bit, left-aligned, count bcnt.
  - Consumption per cycle: k = (SKIP ? SKIPN : 0).
  - If ALIGN is also asserted, k additionally includes (bcnt−k) mod 8. SKIP is applied first, then ALIGN.
  - SKIPN > bcnt, or SKIPN==0 with SKIP high: ERROR←1. bcnt clamps to 0; the buffer is cleared.
  - Refill, same cycle: after consumption, if bcnt−k ≤ 24 and the FIFO is non-empty, pop one byte and place it at bit position bcnt−k from the MSB.
  - Only whole bytes enter the buffer, so bcnt[2:0] is always the partial-byte remainder.
- Outputs:
  - PEEK = buf[31:8], registered.
  - AVAIL = bcnt, registered.
  - READY is combinational from FIFO occupancy.
- FLUSH has priority over all other inputs in its cycle.
- Reset values: READY=1, PEEK=0, AVAIL=0, ERROR=0; FIFO empty, zc=0, epb=0.

## Timing
- Byte strobed at edge t0 is written to the FIFO at t0. Earliest pop into the bit buffer is t1; PEEK/AVAIL reflect it after t1. Latency is 2 cycles from STROBE high to visible bits.
- SKIP/ALIGN sampled at edge t; updated PEEK/AVAIL, including any refill byte, are valid after t. Back-to-back skips every cycle are supported.
- Sustained throughput is one byte in and up to 24 bits out per cycle. Refill is at most one byte per cycle, so sustained consumption above 8 bits/cycle drains the buffer.
- Simultaneous STROBE on a full FIFO and a pop in the same cycle: the write is accepted. The full check uses occupancy after the pop.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits; wrap-around is handled by the extra bit.
- RSTN assertion mid-stream clears all state immediately. The first byte strobed after release is treated as start of stream (zc=0).

## Structure
- Shared package h264_pkg:
  - EPB_BYTE=8'h03
  - BITBUF_W=32
  - PEEK_W=24
  - MAX_SKIP=24
- Sub-module h264_byte_fifo:
  - Ports: CLK, RSTN, FLUSH, write enable/data, pop, empty, full, count.
  - Parameter FIFO_DEPTH.
- The top level holds the unstuff logic, the bit buffer and the shift/merge datapath.

## Test plan
- Strobe 25 00 00 03 01 80 → FIFO receives 25 00 00 01 80. AVAIL reaches 32 then 40 is capped, i.e. AVAIL=32 with one byte left in the FIFO. PEEK=0x250000; SKIP 24 → PEEK[23:8]=0x0180; ERROR=0.
- Strobe 00 00 03 03 → second 03 kept; parser sees 00 00 03; ERROR=0.
- Strobe A5 5A, then SKIP SKIPN=3 → AVAIL=13, PEEK[23:16]=0x2A. Then ALIGN → AVAIL=8, PEEK[23:16]=0x5A.
- No consumption, strobe 21 bytes of 0xFF → READY low after FIFO occupancy exceeds 12. Buffer holds 32 bits, FIFO full at 16, 21st byte lost, ERROR=1.
- Strobe 00 00 01 → ERROR=1, all three bytes delivered. FLUSH → ERROR=0, AVAIL=0, FIFO empty.
- RSTN low for 1 cycle mid-stream with AVAIL=20 → AVAIL=0, PEEK=0, READY=1. Strobe 00 03 after release → both bytes kept (zc restarted).
